// File: rtl/alu_shift_pipe.sv
// alu_shift_pipe: pipelined log shifter (SLL/SRL/SRA, plus ROL/ROR when ALU_SHIFT_PIPE_ROTATE_EN is defined)
// with valid/ready flow control.
module alu_shift_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [2:0]            op_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  illegal_o
);
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);
  localparam int PER = (SHIFT_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;
  typedef struct packed {
    logic                   v;
    logic                   ill;
    logic [2:0]             op;
    logic [SHIFT_WIDTH-1:0] amt;
    logic [TAG_WIDTH-1:0]   tag;
    logic [DATA_WIDTH-1:0]  d;
  } stage_t;
  stage_t s_q [PIPE_STAGES];
  stage_t s_in [PIPE_STAGES];
  stage_t nx [PIPE_STAGES];
  logic en, legal, unused;
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
  assign legal = op_i <= 3'd4;
`else
  assign legal = op_i <= 3'd2;
`endif
  assign en = ~out_valid_o | out_ready_i;
  assign in_ready_o = en;
  assign out_valid_o = s_q[PIPE_STAGES-1].v;
  assign result_o = s_q[PIPE_STAGES-1].d;
  assign tag_o = s_q[PIPE_STAGES-1].tag;
  assign illegal_o = s_q[PIPE_STAGES-1].ill;
  assign unused = ^{rs2_data_i[DATA_WIDTH-1:SHIFT_WIDTH], s_q[PIPE_STAGES-1].op, s_q[PIPE_STAGES-1].amt};
  // Applies the levels whose amount bits fall in [lo, hi); illegal ops carry zero data through.
  function automatic logic [DATA_WIDTH-1:0] shift_stage(input logic [DATA_WIDTH-1:0] x,
      input logic [2:0] op, input logic [SHIFT_WIDTH-1:0] amt, input int lo, input int hi);
    logic [DATA_WIDTH-1:0] y, sra;
    y = x;
    for (int b = 0; b < SHIFT_WIDTH; b++) begin
      if (b >= lo && b < hi && amt[b]) begin
        sra = $signed(y) >>> (1 << b);
        y = op == 3'd0 ? y << (1 << b) :
            op == 3'd1 ? y >> (1 << b) :
            op == 3'd2 ? sra :
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
            op == 3'd3 ? (y << (1 << b)) | (y >> (DATA_WIDTH - (1 << b))) :
            op == 3'd4 ? (y >> (1 << b)) | (y << (DATA_WIDTH - (1 << b))) :
`endif
            y;
      end
    end
    return y;
  endfunction
  always_comb begin
    s_in[0] = '0;
    if (in_valid_i) begin
      s_in[0].v = 1'b1;
      s_in[0].ill = ~legal;
      s_in[0].op = op_i;
      s_in[0].amt = rs2_data_i[SHIFT_WIDTH-1:0];
      s_in[0].tag = tag_i;
      s_in[0].d = legal ? rs1_data_i : '0;
    end
    for (int k = 1; k < PIPE_STAGES; k++) s_in[k] = s_q[k-1];
  end
  always_comb begin
    for (int k = 0; k < PIPE_STAGES; k++) begin
      nx[k] = s_in[k];
      nx[k].d = shift_stage(s_in[k].d, s_in[k].op, s_in[k].amt, k * PER,
                            k == PIPE_STAGES - 1 ? SHIFT_WIDTH : (k + 1) * PER);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < PIPE_STAGES; k++) s_q[k] <= '0;
    else if (en) for (int k = 0; k < PIPE_STAGES; k++) s_q[k] <= nx[k];
  end
endmodule

// File: doc/alu_shift_pipe.md
ALU_SHIFT_PIPE -- requirements
Module: alu_shift_pipe

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32; operand/result width; power of two, 8..64.
- REQ-002 SHALL have parameter PIPE_STAGES, default 2; register stages; legal range 1..$clog2(DATA_WIDTH).
- REQ-003 SHALL have parameter TAG_WIDTH, default 5; sideband tag width (destination register index).
- REQ-004 SHALL derive localparam SHIFT_WIDTH = $clog2(DATA_WIDTH).
- REQ-005 SHALL have port clk, input, 1; sole clock, all state on rising edge.
- REQ-006 SHALL have port rst_n, input, 1; synchronous, active-low reset.
- REQ-007 SHALL have port in_valid_i, input, 1; request valid.
- REQ-008 SHALL have port in_ready_o, output, 1; request accepted when in_valid_i & in_ready_o.
- REQ-009 SHALL have port rs1_data_i, input, DATA_WIDTH; operand to shift.
- REQ-010 SHALL have port rs2_data_i, input, DATA_WIDTH; shift amount source.
- REQ-011 SHALL have port op_i, input, 3; 0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR, 5..7 illegal.
- REQ-012 SHALL have port tag_i, input, TAG_WIDTH; carried unchanged to tag_o.
- REQ-013 SHALL have port out_valid_o, output, 1; result valid.
- REQ-014 SHALL have port out_ready_i, input, 1; consumer accepts when out_valid_o & out_ready_i.
- REQ-015 SHALL have port result_o, output, DATA_WIDTH; shift result.
- REQ-016 SHALL have port tag_o, output, TAG_WIDTH; tag of the result.
- REQ-017 SHALL have port illegal_o, output, 1; asserted with out_valid_o for an illegal op.

Function
- REQ-018 Shift amount SHALL be rs2_data_i[SHIFT_WIDTH-1:0]; upper bits ignored.
- REQ-019 SLL/SRL SHALL zero-fill; SRA SHALL fill with rs1_data_i[DATA_WIDTH-1]; ROL/ROR SHALL rotate with no bit loss.
- REQ-020 Shift by 0 SHALL return rs1_data_i unchanged for every legal op.
- REQ-021 Illegal op SHALL produce result_o=0, illegal_o=1, tag passed through, same latency.
- REQ-022 Log-shifter levels SHALL be split across PIPE_STAGES; stage k resolves shift-amount bits [k*ceil(SHIFT_WIDTH/PIPE_STAGES) ..] upward, last stage takes the remainder.
- REQ-023 Latency SHALL be exactly PIPE_STAGES cycles from acceptance to out_valid_o with out_ready_i held high.
- REQ-024 Throughput SHALL be one op per cycle with no backpressure.
- REQ-025 Advance enable SHALL be en = ~out_valid_o | out_ready_i; in_ready_o = en (combinational path out_ready_i->in_ready_o permitted).
- REQ-026 When en=0 all stages SHALL hold; result_o, tag_o, illegal_o, out_valid_o SHALL stay stable until accepted.
- REQ-027 Bubbles (in_valid_i=0 while en=1) SHALL propagate as invalid stages; outputs SHALL emerge in acceptance order, none lost or duplicated.
- REQ-028 result_o, tag_o, illegal_o SHALL be 0 whenever out_valid_o=0.

Reset
- REQ-029 With rst_n=0 at a rising edge, all stage valid bits, result_o, tag_o, illegal_o SHALL clear to 0.
- REQ-030 in_ready_o SHALL be 1 on the first cycle after reset release.
- REQ-031 Reset mid-operation SHALL discard all in-flight ops; none SHALL appear on the output afterward.

Configuration
- REQ-032 Macro ALU_SHIFT_PIPE_ROTATE_EN SHALL compile in rotate logic.
- REQ-033 With macro defined, ops 3/4 SHALL perform ROL/ROR per REQ-019.
- REQ-034 Without macro, ops 3/4 SHALL be treated as illegal per REQ-021 and no rotate datapath SHALL be synthesised.

Verification (DATA_WIDTH=32, PIPE_STAGES=2)
- REQ-035 SLL rs1=0x00000001, rs2=31 -> result_o=0x80000000, out_valid_o exactly 2 cycles after accept.
- REQ-036 SRA rs1=0x80000000, rs2=4 -> 0xF8000000; SRL same operands -> 0x08000000.
- REQ-037 SLL rs1=0x00000001, rs2=0x00000021 -> 0x00000002 (upper amount bits ignored).
- REQ-038 ROR rs1=0x00000001, rs2=1 -> 0x80000000 with macro; without macro -> result_o=0, illegal_o=1.
- REQ-039 Stream 4 ops tags 1..4, hold out_ready_i=0 for 3 cycles -> in_ready_o=0, outputs held stable, then tags 1,2,3,4 delivered in order.
- REQ-040 Accept 2 ops, assert rst_n=0 for one cycle -> out_valid_o=0, no result delivered, in_ready_o=1 next cycle.
